cyber_player: RTL

Consumes the free-running 10-bit pseudo-random value produced by the LFSR stage and turns it into single-cycle "press" pulses for the computer opponent in the tug-of-war game. Each idle cycle it compares the random value against a 9-bit difficulty level taken from the board switches; a hit issues one press pulse followed by a mandatory cooldown. It sits between the LFSR and the playfield/press-input logic, and also keeps a saturating press count for the score display.

---
 rtl/cyber_player_if.sv | 12 +
 rtl/cyber_player.sv | 68 ++++++
 2 files changed

// File: rtl/cyber_player_if.sv
// Bundle between the LFSR/switch side and the computer-opponent press generator.
interface cyber_player_if #(parameter int CNT_W = 8);
  logic [9:0]       rnd;
  logic [8:0]       level;
  logic             enable;
  logic             press;
  logic             busy;
  logic [CNT_W-1:0] press_count;

  modport master (output rnd, level, enable, input press, busy, press_count);
  modport slave  (input rnd, level, enable, output press, busy, press_count);
endinterface

// File: rtl/cyber_player.sv
// Computer opponent: turns LFSR values into single-cycle press pulses with a
// fixed cooldown after each press, and keeps a saturating press count.
module cyber_player #(
  parameter int COOLDOWN = 4,
  parameter int CNT_W    = 8
) (
  input  logic          Clock,
  input  logic          Reset,
  cyber_player_if.slave bus
);
  localparam int              CD_W    = (COOLDOWN > 1) ? $clog2(COOLDOWN) : 1;
  localparam logic [CD_W-1:0] CD_LOAD = (COOLDOWN > 0) ? CD_W'(COOLDOWN - 1) : '0;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {IDLE, PRESS, COOL} state_t;

  state_t           state_q, state_d;
  logic [CD_W-1:0]  cd_q, cd_d;
  logic             press_q, busy_q;
  logic [CNT_W-1:0] cnt_q;
  logic             hit;

  // level is zero-extended so rnd >= 512 can never hit
  assign hit = bus.rnd < {1'b0, bus.level};

  always_comb begin
    state_d = state_q;
    cd_d    = cd_q;
    case (state_q)
      IDLE:  if (bus.enable && hit) state_d = PRESS;
      PRESS: begin
        if (COOLDOWN > 0) begin
          state_d = COOL;
          cd_d    = CD_LOAD;
        end else begin
          state_d = IDLE;
        end
      end
      COOL: begin
        if (cd_q == '0) state_d = IDLE;
        else            cd_d    = cd_q - CD_W'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  // press/busy are registered from the next state so they line up with state_q
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= IDLE;
      cd_q    <= '0;
      press_q <= 1'b0;
      busy_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cd_q    <= cd_d;
      press_q <= (state_d == PRESS);
      busy_q  <= (state_d != IDLE);
      if (state_q == IDLE && state_d == PRESS && cnt_q != CNT_MAX)
        cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign bus.press       = press_q;
  assign bus.busy        = busy_q;
  assign bus.press_count = cnt_q;
endmodule
